// File: rtl/regfile_write_queue.sv
// regfile_write_queue: FIFO of pending register-file writes, drained one per cycle,
// with read-data forwarding so consumers never observe stale or high-Z operands.
module regfile_write_queue #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_reg,
    input  logic [31:0]   in_data,
    input  logic          wb_stall,
    output logic          rf_writeEnable,
    output logic [4:0]    rf_writeReg,
    output logic [31:0]   rf_writeData,
    input  logic [4:0]    ctrl_readRegA,
    input  logic [4:0]    ctrl_readRegB,
    input  logic [31:0]   rf_readDataA,
    input  logic [31:0]   rf_readDataB,
    output logic [31:0]   data_fwdA,
    output logic [31:0]   data_fwdB,
    output logic [AW:0]   queue_count,
    output logic          queue_empty
);

    logic [4:0]    r_reg  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_ready;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = !w_empty && !wb_stall;
    // A full queue still accepts when the head drains on the same edge.
    assign w_ready = !w_full || w_pop;
    assign w_push  = in_valid && w_ready && (in_reg != 5'd0);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_reg   <= '{default: '0};
            r_data  <= '{default: '0};
        end else begin
            if (w_push) begin
                r_reg[r_tail]  <= in_reg;
                r_data[r_tail] <= in_data;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Walk oldest to newest so the newest matching entry wins; the head is included
    // even while it is being written, which masks the regfile's high-Z read.
    function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] rd);
        logic [31:0]   v;
        logic [AW-1:0] idx;
        v = rd;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = r_head + AW'(k);
            if (((AW+1)'(k) < r_count) && (r_reg[idx] == addr)) begin
                v = r_data[idx];
            end
        end
        if (addr == 5'd0) begin
            v = '0;
        end
        return v;
    endfunction

    assign data_fwdA      = fwd(ctrl_readRegA, rf_readDataA);
    assign data_fwdB      = fwd(ctrl_readRegB, rf_readDataB);

    assign in_ready       = w_ready;
    assign rf_writeEnable = w_pop;
    assign rf_writeReg    = w_empty ? '0 : r_reg[r_head];
    assign rf_writeData   = w_empty ? '0 : r_data[r_head];
    assign queue_count    = r_count;
    assign queue_empty    = w_empty;

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed and random stimulus against a queue-based model
// of the pending writes plus a model of the register file contents.
module tb_regfile_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_reg;
    logic [31:0]   in_data;
    logic          wb_stall;
    logic          rf_writeEnable;
    logic [4:0]    rf_writeReg;
    logic [31:0]   rf_writeData;
    logic [4:0]    ctrl_readRegA;
    logic [4:0]    ctrl_readRegB;
    logic [31:0]   rf_readDataA;
    logic [31:0]   rf_readDataB;
    logic [31:0]   data_fwdA;
    logic [31:0]   data_fwdB;
    logic [AW:0]   queue_count;
    logic          queue_empty;

    regfile_write_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .wb_stall(wb_stall),
        .rf_writeEnable(rf_writeEnable), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .rf_readDataA(rf_readDataA), .rf_readDataB(rf_readDataB),
        .data_fwdA(data_fwdA), .data_fwdB(data_fwdB),
        .queue_count(queue_count), .queue_empty(queue_empty)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [4:0]  q_reg  [$];
    logic [31:0] q_data [$];
    logic [31:0] rf_m   [32];
    logic        exp_push;
    logic        exp_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Regfile behaviour: reads of the register being written this cycle float.
    function automatic logic [31:0] rf_drive(input logic [4:0] a, input logic pop);
        if (a == 5'd0) return 32'h99;
        if (pop && q_reg[0] == a) return 32'hzzzz_zzzz;
        return rf_m[a];
    endfunction

    function automatic logic [31:0] mfwd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        for (int i = q_reg.size() - 1; i >= 0; i--) begin
            if (q_reg[i] == a) return q_data[i];
        end
        return rf_m[a];
    endfunction

    task automatic apply(input logic v, input logic [4:0] r, input logic [31:0] d,
                         input logic st, input logic [4:0] ra, input logic [4:0] rb);
        int   cnt;
        logic pop;
        logic rdy;
        in_valid = v; in_reg = r; in_data = d; wb_stall = st;
        ctrl_readRegA = ra; ctrl_readRegB = rb;
        cnt = q_reg.size();
        pop = (cnt > 0) && !st;
        rdy = (cnt < DEPTH) || pop;
        rf_readDataA = rf_drive(ra, pop);
        rf_readDataB = rf_drive(rb, pop);
        #2;
        chk("in_ready",       32'(in_ready),       32'(rdy));
        chk("rf_writeEnable", 32'(rf_writeEnable), 32'(pop));
        chk("rf_writeReg",    32'(rf_writeReg),    cnt > 0 ? 32'(q_reg[0]) : 32'h0);
        chk("rf_writeData",   rf_writeData,        cnt > 0 ? q_data[0] : 32'h0);
        chk("queue_count",    32'(queue_count),    32'(cnt));
        chk("queue_empty",    32'(queue_empty),    32'(cnt == 0));
        chk("data_fwdA",      data_fwdA,           mfwd(ra));
        chk("data_fwdB",      data_fwdB,           mfwd(rb));
        exp_pop  = pop;
        exp_push = v && rdy && (r != 5'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        if (exp_pop) begin
            rf_m[q_reg[0]] = q_data[0];
            void'(q_reg.pop_front());
            void'(q_data.pop_front());
        end
        if (exp_push) begin
            q_reg.push_back(in_reg);
            q_data.push_back(in_data);
        end
        #1;
    endtask

    task automatic idle(input logic st, input logic [4:0] ra, input logic [4:0] rb);
        apply(1'b0, 5'd0, 32'h0, st, ra, rb);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
        ctrl_reset = 1'b1;
        in_valid = 1'b0; in_reg = '0; in_data = '0; wb_stall = 1'b0;
        ctrl_readRegA = '0; ctrl_readRegB = '0; rf_readDataA = '0; rf_readDataB = '0;
        #1;
        chk("rst_we",    32'(rf_writeEnable), 32'h0);
        chk("rst_reg",   32'(rf_writeReg),    32'h0);
        chk("rst_data",  rf_writeData,        32'h0);
        chk("rst_count", 32'(queue_count),    32'h0);
        chk("rst_empty", 32'(queue_empty),    32'h1);
        chk("rst_ready", 32'(in_ready),       32'h1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b0;

        // Single write latency
        apply(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0); tick();
        idle(1'b0, 5'd5, 5'd0);
        chk("t1_we",   32'(rf_writeEnable), 32'h1);
        chk("t1_reg",  32'(rf_writeReg),    32'h5);
        chk("t1_data", rf_writeData,        32'hDEADBEEF);
        chk("t1_fwdA", data_fwdA,           32'hDEADBEEF);
        tick();
        idle(1'b0, 5'd5, 5'd0);
        chk("t1_empty", 32'(queue_empty), 32'h1);
        chk("t1_rf",    data_fwdA,        32'hDEADBEEF);
        tick();

        // Two writes to the same register under stall
        apply(1'b1, 5'd3, 32'h11, 1'b1, 5'd0, 5'd0); tick();
        apply(1'b1, 5'd3, 32'h22, 1'b1, 5'd0, 5'd0); tick();
        idle(1'b1, 5'd3, 5'd0);
        chk("t2_fwdA",  data_fwdA,        32'h22);
        chk("t2_count", 32'(queue_count), 32'h2);
        tick();
        idle(1'b0, 5'd3, 5'd3);
        chk("t2_w1", rf_writeData, 32'h11);
        tick();
        idle(1'b0, 5'd3, 5'd3);
        chk("t2_w2",   rf_writeData, 32'h22);
        chk("t2_fwdZ", data_fwdA,    32'h22);
        tick();

        // Head being written while the regfile read floats
        apply(1'b1, 5'd7, 32'hABCD, 1'b1, 5'd0, 5'd0); tick();
        idle(1'b0, 5'd7, 5'd7);
        chk("t3_fwdA", data_fwdA, 32'hABCD);
        chk("t3_fwdB", data_fwdB, 32'hABCD);
        tick();

        // Fill under stall, then simultaneous push and pop when full
        for (int i = 1; i <= 4; i++) begin
            apply(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'(i), 5'd2); tick();
        end
        idle(1'b1, 5'd1, 5'd4);
        chk("t4_count", 32'(queue_count), 32'h4);
        chk("t4_ready", 32'(in_ready),    32'h0);
        tick();
        apply(1'b1, 5'd9, 32'h909, 1'b0, 5'd1, 5'd9);
        chk("t4_ready2", 32'(in_ready), 32'h1);
        tick();
        idle(1'b1, 5'd9, 5'd2);
        chk("t4_count2", 32'(queue_count), 32'h4);
        tick();
        repeat (5) begin idle(1'b0, 5'd9, 5'd4); tick(); end

        // Register zero is accepted but dropped, and reads as zero
        apply(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 5'd0);
        chk("t5_ready", 32'(in_ready), 32'h1);
        chk("t5_fwdA",  data_fwdA,     32'h0);
        tick();
        idle(1'b0, 5'd0, 5'd0);
        chk("t5_count", 32'(queue_count),    32'h0);
        chk("t5_we",    32'(rf_writeEnable), 32'h0);
        tick();

        // Asynchronous reset mid-drain discards queued writes
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 5'(10 + i), 32'hC0 + 32'(i), 1'b1, 5'd0, 5'd0); tick();
        end
        idle(1'b0, 5'd10, 5'd11);
        ctrl_reset = 1'b1;
        #1;
        chk("t6_we",    32'(rf_writeEnable), 32'h0);
        chk("t6_reg",   32'(rf_writeReg),    32'h0);
        chk("t6_data",  rf_writeData,        32'h0);
        chk("t6_count", 32'(queue_count),    32'h0);
        chk("t6_empty", 32'(queue_empty),    32'h1);
        q_reg.delete();
        q_data.delete();
        @(posedge clock);
        #1;
        ctrl_reset = 1'b0;
        repeat (4) begin idle(1'b0, 5'd10, 5'd12); tick(); end

        // Random traffic over a small register set so forwarding hits often
        repeat (400) begin
            apply($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        // Long stall: queue saturates, forwarding must hold
        repeat (10) begin
            apply(1'b1, 5'($urandom_range(1, 6)), $urandom, 1'b1,
                  5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)));
            tick();
        end
        repeat (8) begin
            idle(1'b0, 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side initiator for the 32x32 register file: buffers writeback requests from the execute/memory stages in a small FIFO and drains them into the register-file write port one per cycle.
- The register file returns high-Z on a read port whose address matches the register being written that cycle. This block forwards the correct data for any register with a queued or in-flight write, so consumers never see Z or stale values.
- Sits between the writeback stage and the regfile's write and read-data ports.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, legal range 2..16.
- AW, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clock  input  1  system clock, rising-edge.
- ctrl_reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  writeback request valid.
- in_ready  output  1  queue can accept a request this cycle.
- in_reg  input  5  destination register number.
- in_data  input  32  writeback data.
- wb_stall  input  1  regfile write port unavailable this cycle; no drain.
- rf_writeEnable  output  1  drives regfile ctrl_writeEnable.
- rf_writeReg  output  5  drives regfile ctrl_writeReg.
- rf_writeData  output  32  drives regfile data_writeReg.
- ctrl_readRegA  input  5  read address A, same value the core drives to the regfile.
- ctrl_readRegB  input  5  read address B, same value the core drives to the regfile.
- rf_readDataA  input  32  regfile data_readRegA.
- rf_readDataB  input  32  regfile data_readRegB.
- data_fwdA  output  32  corrected operand A.
- data_fwdB  output  32  corrected operand B.
- queue_count  output  AW+1  number of valid entries.
- queue_empty  output  1  queue_count == 0.

Behaviour:
- Reset (async, takes effect immediately, including mid-drain):
  - head, tail and count go to 0; all entries are invalidated.
  - rf_writeEnable=0, rf_writeReg=0, rf_writeData=0, queue_count=0, queue_empty=1, in_ready=1.
  - Entries queued before reset are discarded and never written.
- Storage: circular FIFO of {reg[4:0], data[31:0]}. Pointers wrap modulo DEPTH.
- Enqueue on the rising edge when in_valid && in_ready && in_reg != 0.
  - in_valid with in_reg == 0 is accepted (handshake completes) but not stored, and count is unchanged.
- Drain: pop = !queue_empty && !wb_stall.
- Write port outputs are combinational from the head entry:
  - rf_writeEnable = pop; rf_writeReg and rf_writeData = head entry while nonempty.
  - When empty, rf_writeReg=0 and rf_writeData=0.
  - The regfile commits the write on the same edge as the pop.
- in_ready = (count < DEPTH) || pop. When full and draining, enqueue and pop happen on the same edge and count stays DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: an accepted request on an empty, unstalled queue appears on the write port the cycle after acceptance; it is committed at the end of that cycle.
- Forwarding, evaluated independently for ports A and B, purely combinational:
  - Address 0 -> output 0.
  - Otherwise, scan valid entries newest (tail-1) to oldest (head). Output the data of the newest entry whose reg matches.
  - The head entry participates even when it is being written this cycle, which covers the regfile's Z case.
  - No match -> rf_readDataX passes through.
- The in_* request of the current cycle is not forwarded; it is visible from the next cycle.
- Multiple queued writes to the same register are all written in order; the final regfile value is the newest.
- wb_stall held indefinitely: queue fills, in_ready=0, and forwarding stays correct.

Test Plan:
- Reset, then push r5=0xDEADBEEF -> next cycle rf_writeEnable=1, rf_writeReg=5, rf_writeData=0xDEADBEEF; the following cycle queue_empty=1.
- wb_stall=1, push r3=0x11 then r3=0x22, read A=3 with rf_readDataA=0 -> data_fwdA=0x22, queue_count=2. Release stall -> writes of 0x11 then 0x22 on consecutive cycles.
- Head write r7=0xABCD draining while rf_readDataA=Z and readRegA=7 -> data_fwdA=0xABCD, never X/Z.
- wb_stall=1, push 4 entries -> queue_count=4, in_ready=0. Drop stall with in_valid=1 -> push and pop on the same edge, queue_count stays 4.
- Push in_reg=0 with data 0x5 -> in_ready=1, queue_count unchanged, no regfile write. Read A=0 with rf_readDataA=0x99 -> data_fwdA=0.
- Three entries queued under stall, assert ctrl_reset mid-cycle -> outputs zero immediately, queue_count=0, no queued write ever appears on rf_writeEnable.
